vga_timing_gen: RTL and testbench

Parametrised raster timing generator for the VGA output path. It divides the system clock into a pixel-rate enable and runs horizontal and vertical position counters with fully configurable display, porch and sync lengths. It produces registered sync, blanking, position and line/frame markers for the pixel generators and the DAC/VGA pins. Sync polarity and clock-to-pixel ratio are parameters, so one block serves 640x480@60, 800x600 and other modes.

---
 rtl/vga_timing_gen.sv | 150 +++++++++++++++
 tb/tb_vga_timing_gen.sv | 338 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_timing_gen.sv
// Raster timing generator: pixel-rate enable, x/y position counters and registered
// sync/blank/marker outputs. Define VGA_FRAME_CNT_EN to build the completed-frame counter.
module vga_timing_gen #(
    parameter int CLK_DIV   = 2,
    parameter int CW        = 11,
    parameter int H_DISPLAY = 640,
    parameter int H_FRONT   = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BACK    = 48,
    parameter int V_DISPLAY = 480,
    parameter int V_FRONT   = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BACK    = 33,
    parameter bit H_POL     = 1'b0,
    parameter bit V_POL     = 1'b0,
    parameter int FRAME_W   = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    output logic               p_tick,
    output logic [CW-1:0]      x,
    output logic [CW-1:0]      y,
    output logic               hsync,
    output logic               vsync,
    output logic               video_on,
    output logic               line_start,
    output logic               frame_start,
    output logic [FRAME_W-1:0] frame_cnt
);

    localparam int H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;
    localparam int DW      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [DW-1:0] DIV_LAST    = DW'(CLK_DIV - 1);
    localparam logic [CW-1:0] X_LAST      = CW'(H_TOTAL - 1);
    localparam logic [CW-1:0] Y_LAST      = CW'(V_TOTAL - 1);
    localparam logic [CW-1:0] X_DISP_LAST = CW'(H_DISPLAY - 1);
    localparam logic [CW-1:0] Y_DISP_LAST = CW'(V_DISPLAY - 1);
    localparam logic [CW-1:0] HS_FIRST    = CW'(H_DISPLAY + H_FRONT);
    localparam logic [CW-1:0] HS_LAST     = CW'(H_DISPLAY + H_FRONT + H_SYNC - 1);
    localparam logic [CW-1:0] VS_FIRST    = CW'(V_DISPLAY + V_FRONT);
    localparam logic [CW-1:0] VS_LAST     = CW'(V_DISPLAY + V_FRONT + V_SYNC - 1);

    logic [DW-1:0] div_q, div_d;
    logic          p_tick_q, p_tick_d;
    logic [CW-1:0] x_q, x_d;
    logic [CW-1:0] y_q, y_d;
    logic          hsync_q, hsync_d;
    logic          vsync_q, vsync_d;
    logic          video_on_q, video_on_d;
    logic          line_start_q, line_start_d;
    logic          frame_start_q, frame_start_d;

    // p_tick is raised one clk ahead so it marks the cycle whose closing edge advances x/y.
    // NOTE: every always_comb target gets a default assignment first, so no latch is inferred.
    always_comb begin : div_next
        div_d = div_q + 1'b1;
        if (div_q == DIV_LAST) begin
            div_d = '0;
        end
        p_tick_d = (div_d == DIV_LAST);
    end

    always_comb begin : pos_next
        x_d = x_q;
        y_d = y_q;
        if (p_tick_q) begin
            if (x_q == X_LAST) begin
                x_d = '0;
                y_d = (y_q == Y_LAST) ? '0 : y_q + 1'b1;
            end else begin
                x_d = x_q + 1'b1;
            end
        end
    end

    // Decoding the next position keeps every marker cycle-aligned with the registered x/y.
    always_comb begin : decode_next
        hsync_d       = ((x_d >= HS_FIRST) && (x_d <= HS_LAST)) ? H_POL : ~H_POL;
        vsync_d       = ((y_d >= VS_FIRST) && (y_d <= VS_LAST)) ? V_POL : ~V_POL;
        video_on_d    = (x_d <= X_DISP_LAST) && (y_d <= Y_DISP_LAST);
        line_start_d  = (x_d == '0);
        frame_start_d = (x_d == '0) && (y_d == '0);
    end

    // rst_n is expected to be released synchronously upstream; assertion is asynchronous.
    // NOTE: sequential state uses non-blocking assignments so all flops sample pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin : state_reg
        if (!rst_n) begin
            div_q         <= '0;
            p_tick_q      <= 1'b0;
            x_q           <= X_LAST;
            y_q           <= Y_LAST;
            hsync_q       <= ~H_POL;
            vsync_q       <= ~V_POL;
            video_on_q    <= 1'b0;
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            div_q         <= div_d;
            p_tick_q      <= p_tick_d;
            x_q           <= x_d;
            y_q           <= y_d;
            hsync_q       <= hsync_d;
            vsync_q       <= vsync_d;
            video_on_q    <= video_on_d;
            line_start_q  <= line_start_d;
            frame_start_q <= frame_start_d;
        end
    end

`ifdef VGA_FRAME_CNT_EN
    logic               started_q, started_d;
    logic [FRAME_W-1:0] frame_cnt_q, frame_cnt_d;

    // The wrap out of the reset position is not a completed frame, hence the started flag.
    always_comb begin : frame_cnt_next
        started_d   = started_q | p_tick_q;
        frame_cnt_d = frame_cnt_q;
        if (p_tick_q && started_q && (x_q == X_LAST) && (y_q == Y_LAST)) begin
            frame_cnt_d = frame_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin : frame_cnt_reg
        if (!rst_n) begin
            started_q   <= 1'b0;
            frame_cnt_q <= '0;
        end else begin
            started_q   <= started_d;
            frame_cnt_q <= frame_cnt_d;
        end
    end

    assign frame_cnt = frame_cnt_q;
`else
    assign frame_cnt = '0;
`endif

    assign p_tick      = p_tick_q;
    assign x           = x_q;
    assign y           = y_q;
    assign hsync       = hsync_q;
    assign vsync       = vsync_q;
    assign video_on    = video_on_q;
    assign line_start  = line_start_q;
    assign frame_start = frame_start_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: two small-raster instances (CLK_DIV=2 active-low syncs,
// CLK_DIV=1 active-high syncs) scored every clk against an arithmetic position model.
module tb_vga_timing_gen;

    typedef struct packed {
        int div; int hd; int hf; int hs; int hb;
        int vd; int vf; int vs; int vb;
        int hpol; int vpol; int fw;
    } cfg_t;

    typedef struct packed {
        logic        p_tick;
        logic [31:0] x;
        logic [31:0] y;
        logic        hsync;
        logic        vsync;
        logic        video_on;
        logic        line_start;
        logic        frame_start;
        logic [31:0] frame_cnt;
    } out_t;

    localparam cfg_t CFG_A = '{div: 2, hd: 8, hf: 2, hs: 3, hb: 2, vd: 4, vf: 1, vs: 2, vb: 1,
                               hpol: 0, vpol: 0, fw: 2};
    localparam cfg_t CFG_B = '{div: 1, hd: 6, hf: 1, hs: 2, hb: 1, vd: 3, vf: 1, vs: 1, vb: 1,
                               hpol: 1, vpol: 1, fw: 16};
    localparam int A_HT = 15, A_VT = 8, A_CW = 5, A_FW = 2;
    localparam int B_HT = 10, B_VT = 6, B_CW = 4, B_FW = 16;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    logic            p_tick_a, hsync_a, vsync_a, video_on_a, line_start_a, frame_start_a;
    logic [A_CW-1:0] x_a, y_a;
    logic [A_FW-1:0] frame_cnt_a;
    logic            p_tick_b, hsync_b, vsync_b, video_on_b, line_start_b, frame_start_b;
    logic [B_CW-1:0] x_b, y_b;
    logic [B_FW-1:0] frame_cnt_b;

    int vectors = 0;
    int miscompares = 0;
    int n_edges = 0;
    out_t q_a[$];
    out_t q_b[$];

    int hs_a, vs_a, von_a, hs_b, vs_b, von_b, pt_b;
    int fs_last_a = -1, fs_last_b = -1, fs_per_a = 0, fs_per_b = 0;
    int ls_last_a = -1, ls_last_b = -1, ls_per_a = 0, ls_per_b = 0;
    logic fs_prev_a = 1'b0, fs_prev_b = 1'b0, ls_prev_a = 1'b0, ls_prev_b = 1'b0;

    vga_timing_gen #(
        .CLK_DIV(2), .CW(A_CW), .H_DISPLAY(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(2),
        .V_DISPLAY(4), .V_FRONT(1), .V_SYNC(2), .V_BACK(1), .H_POL(1'b0), .V_POL(1'b0),
        .FRAME_W(A_FW)
    ) dut_a (
        .clk(clk), .rst_n(rst_n), .p_tick(p_tick_a), .x(x_a), .y(y_a),
        .hsync(hsync_a), .vsync(vsync_a), .video_on(video_on_a),
        .line_start(line_start_a), .frame_start(frame_start_a), .frame_cnt(frame_cnt_a)
    );

    vga_timing_gen #(
        .CLK_DIV(1), .CW(B_CW), .H_DISPLAY(6), .H_FRONT(1), .H_SYNC(2), .H_BACK(1),
        .V_DISPLAY(3), .V_FRONT(1), .V_SYNC(1), .V_BACK(1), .H_POL(1'b1), .V_POL(1'b1),
        .FRAME_W(B_FW)
    ) dut_b (
        .clk(clk), .rst_n(rst_n), .p_tick(p_tick_b), .x(x_b), .y(y_b),
        .hsync(hsync_b), .vsync(vsync_b), .video_on(video_on_b),
        .line_start(line_start_b), .frame_start(frame_start_b), .frame_cnt(frame_cnt_b)
    );

    always #5 clk = ~clk;

    // Expected outputs after rising edge n since reset release (n = 0 while in reset).
    function automatic out_t model(input cfg_t c, input int n);
        out_t o;
        int f, ht, vt, a, p, xi, yi;
        f  = (c.div > 2) ? c.div : 2;
        ht = c.hd + c.hf + c.hs + c.hb;
        vt = c.vd + c.vf + c.vs + c.vb;
        a  = (n < f) ? 0 : ((n - f) / c.div) + 1;
        o.frame_cnt = 32'd0;
        if (a == 0) begin
            xi = ht - 1;
            yi = vt - 1;
        end else begin
            p  = a - 1;
            xi = p % ht;
            yi = (p / ht) % vt;
`ifdef VGA_FRAME_CNT_EN
            o.frame_cnt = 32'((p / (ht * vt)) % (1 << c.fw));
`endif
        end
        o.x           = 32'(xi);
        o.y           = 32'(yi);
        o.p_tick      = ((n + 1) >= f) && (((n + 1 - f) % c.div) == 0);
        o.hsync       = ((xi >= c.hd + c.hf) && (xi < c.hd + c.hf + c.hs)) ? 1'(c.hpol) : ~1'(c.hpol);
        o.vsync       = ((yi >= c.vd + c.vf) && (yi < c.vd + c.vf + c.vs)) ? 1'(c.vpol) : ~1'(c.vpol);
        o.video_on    = (xi < c.hd) && (yi < c.vd);
        o.line_start  = (xi == 0);
        o.frame_start = (xi == 0) && (yi == 0);
        return o;
    endfunction

    function automatic out_t sample_a();
        out_t o;
        o = '{p_tick: p_tick_a, x: 32'(x_a), y: 32'(y_a), hsync: hsync_a, vsync: vsync_a,
              video_on: video_on_a, line_start: line_start_a, frame_start: frame_start_a,
              frame_cnt: 32'(frame_cnt_a)};
        return o;
    endfunction

    function automatic out_t sample_b();
        out_t o;
        o = '{p_tick: p_tick_b, x: 32'(x_b), y: 32'(y_b), hsync: hsync_b, vsync: vsync_b,
              video_on: video_on_b, line_start: line_start_b, frame_start: frame_start_b,
              frame_cnt: 32'(frame_cnt_b)};
        return o;
    endfunction

    function automatic string fmt(input out_t o);
        return $sformatf("x=%0d y=%0d pt=%b hs=%b vs=%b von=%b ls=%b fs=%b fc=%0d",
                         o.x, o.y, o.p_tick, o.hsync, o.vsync, o.video_on,
                         o.line_start, o.frame_start, o.frame_cnt);
    endfunction

    // One clk: push expectations at the rising edge, pop and score them at the falling edge.
    task automatic step();
        out_t e, o;
        @(posedge clk);
        if (rst_n) n_edges++;
        q_a.push_back(model(CFG_A, n_edges));
        q_b.push_back(model(CFG_B, n_edges));
        @(negedge clk);
        e = q_a.pop_front();
        o = sample_a();
        vectors++;
        if (o !== e) begin
            miscompares++;
            $display("FAIL scoreboard_a edge %0d: got %s, expected %s", n_edges, fmt(o), fmt(e));
        end
        e = q_b.pop_front();
        o = sample_b();
        vectors++;
        if (o !== e) begin
            miscompares++;
            $display("FAIL scoreboard_b edge %0d: got %s, expected %s", n_edges, fmt(o), fmt(e));
        end
        if (hsync_a == 1'b0) hs_a++;
        if (vsync_a == 1'b0) vs_a++;
        if (video_on_a) von_a++;
        if (hsync_b == 1'b1) hs_b++;
        if (vsync_b == 1'b1) vs_b++;
        if (video_on_b) von_b++;
        if (p_tick_b) pt_b++;
        if (frame_start_a && !fs_prev_a) begin
            if (fs_last_a >= 0) fs_per_a = n_edges - fs_last_a;
            fs_last_a = n_edges;
        end
        if (frame_start_b && !fs_prev_b) begin
            if (fs_last_b >= 0) fs_per_b = n_edges - fs_last_b;
            fs_last_b = n_edges;
        end
        if (line_start_a && !ls_prev_a) begin
            if (ls_last_a >= 0) ls_per_a = n_edges - ls_last_a;
            ls_last_a = n_edges;
        end
        if (line_start_b && !ls_prev_b) begin
            if (ls_last_b >= 0) ls_per_b = n_edges - ls_last_b;
            ls_last_b = n_edges;
        end
        fs_prev_a = frame_start_a;
        fs_prev_b = frame_start_b;
        ls_prev_a = line_start_a;
        ls_prev_b = line_start_b;
    endtask

    task automatic clear_counts();
        hs_a = 0; vs_a = 0; von_a = 0; hs_b = 0; vs_b = 0; von_b = 0; pt_b = 0;
    endtask

    task automatic release_reset();
        #1 rst_n = 1'b1;
        n_edges = 0;
    endtask

    task automatic test_reset();
        repeat (3) step();
        vectors++;
        if (x_a !== 5'd14 || y_a !== 5'd7 || hsync_a !== 1'b1 || vsync_a !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_a: got x=%0d y=%0d hs=%b vs=%b, expected x=14 y=7 hs=1 vs=1",
                     x_a, y_a, hsync_a, vsync_a);
        end
        vectors++;
        if (x_b !== 4'd9 || y_b !== 4'd5 || hsync_b !== 1'b0 || vsync_b !== 1'b0 || p_tick_b !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_b: got x=%0d y=%0d hs=%b vs=%b pt=%b, expected x=9 y=5 hs=0 vs=0 pt=0",
                     x_b, y_b, hsync_b, vsync_b, p_tick_b);
        end
        release_reset();
    endtask

    task automatic test_first_frame();
        step();
        vectors++;
        if (x_a !== 5'd14 || video_on_a !== 1'b0 || p_tick_a !== 1'b1 || p_tick_b !== 1'b1) begin
            miscompares++;
            $display("FAIL edge1: got x_a=%0d von_a=%b pt_a=%b pt_b=%b, expected 14 0 1 1",
                     x_a, video_on_a, p_tick_a, p_tick_b);
        end
        clear_counts();
        for (int i = 0; i < 2; i++) begin
            step();
            vectors++;
            if (x_a !== 5'd0 || y_a !== 5'd0 || frame_start_a !== 1'b1 || video_on_a !== 1'b1) begin
                miscompares++;
                $display("FAIL first_pixel clk %0d: got x=%0d y=%0d fs=%b von=%b, expected 0 0 1 1",
                         i, x_a, y_a, frame_start_a, video_on_a);
            end
        end
        step();
        vectors++;
        if (x_a !== 5'd1 || frame_start_a !== 1'b0) begin
            miscompares++;
            $display("FAIL second_pixel: got x=%0d fs=%b, expected x=1 fs=0", x_a, frame_start_a);
        end
        repeat (237) step();
        vectors++;
        if (hs_a != A_VT * 3 * 2 || vs_a != 2 * A_HT * 2 || von_a != 4 * 8 * 2) begin
            miscompares++;
            $display("FAIL frame_counts_a: got hs=%0d vs=%0d von=%0d, expected %0d %0d %0d",
                     hs_a, vs_a, von_a, A_VT * 6, 4 * A_HT, 64);
        end
        vectors++;
        if (hs_b != 4 * B_VT * 2 || vs_b != 4 * B_HT || von_b != 4 * 3 * 6 || pt_b != 240) begin
            miscompares++;
            $display("FAIL frame_counts_b: got hs=%0d vs=%0d von=%0d pt=%0d, expected %0d %0d %0d 240",
                     hs_b, vs_b, von_b, pt_b, 8 * B_VT, 4 * B_HT, 72);
        end
    endtask

    task automatic test_periods();
        repeat (300) step();
        vectors++;
        if (fs_per_a != A_HT * A_VT * 2 || ls_per_a != A_HT * 2) begin
            miscompares++;
            $display("FAIL period_a: got frame=%0d line=%0d, expected %0d %0d",
                     fs_per_a, ls_per_a, A_HT * A_VT * 2, A_HT * 2);
        end
        vectors++;
        if (fs_per_b != B_HT * B_VT || ls_per_b != B_HT) begin
            miscompares++;
            $display("FAIL period_b: got frame=%0d line=%0d, expected %0d %0d",
                     fs_per_b, ls_per_b, B_HT * B_VT, B_HT);
        end
    endtask

    task automatic test_mid_reset();
        out_t o, e;
        repeat (37) step();
        #1 rst_n = 1'b0;
        #1;
        n_edges = 0;
        fs_last_a = -1; fs_last_b = -1; ls_last_a = -1; ls_last_b = -1;
        o = sample_a();
        e = model(CFG_A, 0);
        vectors++;
        if (o !== e) begin
            miscompares++;
            $display("FAIL async_reset_a: got %s, expected %s", fmt(o), fmt(e));
        end
        o = sample_b();
        e = model(CFG_B, 0);
        vectors++;
        if (o !== e) begin
            miscompares++;
            $display("FAIL async_reset_b: got %s, expected %s", fmt(o), fmt(e));
        end
        repeat (2) step();
        release_reset();
        step();
        vectors++;
        if (x_a !== 5'd14 || y_a !== 5'd7) begin
            miscompares++;
            $display("FAIL restart_edge1: got x=%0d y=%0d, expected 14 7", x_a, y_a);
        end
        step();
        vectors++;
        if (x_a !== 5'd0 || y_a !== 5'd0 || frame_start_a !== 1'b1) begin
            miscompares++;
            $display("FAIL restart_edge2: got x=%0d y=%0d fs=%b, expected 0 0 1", x_a, y_a, frame_start_a);
        end
    endtask

    task automatic test_frame_cnt();
        int want;
        vectors++;
        if (frame_cnt_a !== 2'd0) begin
            miscompares++;
            $display("FAIL frame_cnt frame0: got %0d, expected 0", frame_cnt_a);
        end
        for (int k = 1; k <= 4; k++) begin
            repeat (A_HT * A_VT * 2) step();
`ifdef VGA_FRAME_CNT_EN
            want = k % 4;
`else
            want = 0;
`endif
            vectors++;
            if (32'(frame_cnt_a) !== 32'(want) || frame_start_a !== 1'b1) begin
                miscompares++;
                $display("FAIL frame_cnt frame%0d: got cnt=%0d fs=%b, expected cnt=%0d fs=1",
                         k, frame_cnt_a, frame_start_a, want);
            end
        end
`ifdef VGA_FRAME_CNT_EN
        want = 16;
`else
        want = 0;
`endif
        vectors++;
        if (32'(frame_cnt_b) !== 32'(want)) begin
            miscompares++;
            $display("FAIL frame_cnt_b: got %0d, expected %0d", frame_cnt_b, want);
        end
    endtask

    initial begin
        test_reset();
        test_first_frame();
        test_periods();
        test_mid_reset();
        test_frame_cnt();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
